linear_layer_start_fifo_ctrl: RTL and testbench
===============================================

# linear_layer_start_fifo_ctrl

Pointer/flag controller for the Linear_Layer start-token FIFOs. It owns the SRL shift-register storage and turns it into a first-word-fall-through FIFO with write/read handshakes. It sits between a producer task's start-propagation output and the consumer PE's `ap_start`, one instance per PE. It generates the write-enable and read address the storage needs, plus full/empty flags and an occupancy count.

## Interface
- `DATA_WIDTH`, 1: token/data width in bits.
- `ADDR_WIDTH`, 1: SRL address width; must satisfy 2^ADDR_WIDTH >= DEPTH.
- `DEPTH`, 2: FIFO capacity in entries, >= 2.
- `ap_clk`  in  1  clock; all state updates on the rising edge.
- `ap_rst_n`  in  1  reset; asynchronous and active-low.
- `if_write_ce`  in  1  write-side clock enable.
- `if_write`  in  1  producer push request.
- `if_din`  in  DATA_WIDTH  push data.
- `if_full_n`  out  1  1 = space available.
- `if_read_ce`  in  1  read-side clock enable.
- `if_read`  in  1  consumer pop request.
- `if_dout`  out  DATA_WIDTH  head-of-FIFO data, valid while `if_empty_n`=1.
- `if_empty_n`  out  1  1 = data available.
- `if_count`  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.

## Operation
- push = `if_write` & `if_write_ce` & `if_full_n`.
- pop = `if_read` & `if_read_ce` & `if_empty_n`.
- A push attempted while full, or a pop attempted while empty, is ignored with no state change.
- Storage is a shift register. On push, all entries shift up by one and `if_din` enters slot 0. The oldest entry sits at slot `ptr`.
- `ptr` is signed, ADDR_WIDTH+1 bits wide. Its reset value is -1 (all ones), meaning empty.
- Pointer update rules:
  - push only: ptr+1.
  - pop only: ptr-1.
  - push and pop together: ptr holds, and the SRL still shifts.
  - neither: hold.
- The SRL read address is `ptr[ADDR_WIDTH-1:0]`. `if_dout` is combinational from the SRL at that address (first-word fall-through).
- Flags are registered:
  - `if_empty_n`: set to 1 on push-only. Cleared on pop-only when ptr==0.
  - `if_full_n`: cleared on push-only when ptr==DEPTH-2. Set to 1 on pop-only.
  - Simultaneous push and pop leaves both flags unchanged.
- `if_count` is a registered counter kept consistent with ptr: count == ptr+1 at all times.
- Reset values: ptr=-1, `if_empty_n`=0, `if_full_n`=1, `if_count`=0. SRL contents are not reset, so `if_dout` is don't-care while empty.
- Reset asserted mid-operation discards all entries immediately (asynchronously). Outputs return to their reset values without waiting for a clock edge.
- Simultaneous push and pop on an empty FIFO cannot occur, because pop requires `if_empty_n`=1; only the push takes effect. On a full FIFO only the pop is qualified, so the result is pop-only.

## Timing
- Write-to-read latency is 1 cycle: after a push at edge t, `if_empty_n`=1 and `if_dout`=data from edge t on.
- Pop-to-space latency is 1 cycle: after a pop at edge t, `if_full_n`=1 from edge t.
- Sustained throughput is 1 push and 1 pop per cycle at any occupancy 1..DEPTH-1.
- There is no combinational path from `if_read` to `if_full_n`, or from `if_write` to `if_empty_n`.
- `if_dout` changes combinationally with ptr or SRL contents only after a clock edge.

## Structure
- Sub-module `linear_layer_start_fifo_srl` holds the storage. Ports: clk, we, addr, din, dout. It has no reset and is implemented as SRL-inferable shift logic.
- The controller contains only ptr, the flags and the count.
- Shared package `linear_layer_pkg` holds:
  - `START_FIFO_DEPTH_DEFAULT`=2.
  - The function `clog2_min1(depth)` that derives ADDR_WIDTH.
  - The typedef for start tokens.

## Test plan
All scenarios use DATA_WIDTH=8, DEPTH=2, ADDR_WIDTH=1.
- Reset check: hold `ap_rst_n`=0 → `if_empty_n`=0, `if_full_n`=1, `if_count`=0. Release reset, drive no traffic for 5 cycles → no change.
- Fill: push 0xA1 then 0xB2 on consecutive cycles. Expect `if_empty_n`=1 and `if_dout`=0xA1 after the first push; `if_full_n`=0 and `if_count`=2 after the second. A third push of 0xC3 is dropped: count stays 2 and the data is never seen.
- Drain: from full, pop twice. Expect `if_dout` 0xA1 then 0xB2, `if_full_n`=1 after the first pop, `if_empty_n`=0 after the second. A further pop is ignored and count stays 0.
- Streaming: hold one entry (0x10), then push 0x11..0x1F while popping each cycle. Expect the output order 0x10..0x1F, count fixed at 1, and both flags constant at 1.
- Clock enables: `if_write`=1 with `if_write_ce`=0, and `if_read`=1 with `if_read_ce`=0, for 4 cycles → no state change.
- Async reset with the FIFO full: assert `ap_rst_n`=0 between clock edges. Before the next edge expect `if_empty_n`=0, `if_full_n`=1, `if_count`=0. After release, push 0x5A → `if_dout`=0x5A.

Source files
------------

// File: rtl/linear_layer_pkg.sv
// Shared definitions for the Linear_Layer start-token plumbing.
package linear_layer_pkg;

    // Default capacity of each per-PE start-token FIFO.
    localparam int START_FIFO_DEPTH_DEFAULT = 2;

    // A start token is a single bit that releases one ap_start of the consumer PE.
    typedef logic start_token_t;

    // Address width for an SRL holding 'depth' entries; never below one bit.
    function automatic int clog2_min1(input int depth);
        if (depth <= 2) begin
            return 1;
        end
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/linear_layer_start_fifo_srl.sv
// Shift-register storage for the start-token FIFO: new data enters slot 0,
// older entries move up one slot, and any slot can be read combinationally.
module linear_layer_start_fifo_srl
    import linear_layer_pkg::*;
#(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = clog2_min1(START_FIFO_DEPTH_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam int SLOTS = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [0:SLOTS-1];

    // Shift every slot up by one and load din into slot 0 on each write; no reset so it maps onto SRL primitives.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[0] <= din;
            for (int i = 1; i < SLOTS; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    // Asynchronous read of the addressed slot, giving first-word fall-through at the head.
    always_comb begin
        dout = mem[addr];
    end

endmodule

// File: rtl/linear_layer_start_fifo_ctrl.sv
// Pointer/flag controller turning the SRL storage into a first-word-fall-through
// FIFO. ptr marks the slot of the oldest entry; -1 means empty.
module linear_layer_start_fifo_ctrl
    import linear_layer_pkg::*;
#(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = clog2_min1(START_FIFO_DEPTH_DEFAULT),
    parameter int DEPTH      = START_FIFO_DEPTH_DEFAULT
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    output logic [ADDR_WIDTH:0]   if_count
);

    localparam int PW = ADDR_WIDTH + 1;

    localparam logic signed [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic signed [PW-1:0] PTR_ZERO  = PW'(0);
    localparam logic signed [PW-1:0] PTR_LAST  = PW'(DEPTH - 2);
    localparam logic        [PW-1:0] CNT_ONE   = PW'(1);

    logic signed [PW-1:0] ptr;
    logic                 push;
    logic                 pop;

    // Qualify requests against enables and the registered flags, so a blocked request never reaches state.
    always_comb begin
        push = if_write & if_write_ce & if_full_n;
        pop  = if_read  & if_read_ce  & if_empty_n;
    end

    // Pointer, count and flag registers; a simultaneous push and pop keeps ptr, count and flags steady while the SRL shifts.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ptr        <= '1;
            if_count   <= '0;
            if_empty_n <= 1'b0;
            if_full_n  <= 1'b1;
        end else if (push && !pop) begin
            ptr        <= ptr + PTR_ONE;
            if_count   <= if_count + CNT_ONE;
            if_empty_n <= 1'b1;
            if (ptr == PTR_LAST) begin
                if_full_n <= 1'b0;
            end
        end else if (pop && !push) begin
            ptr        <= ptr - PTR_ONE;
            if_count   <= if_count - CNT_ONE;
            if_full_n  <= 1'b1;
            if (ptr == PTR_ZERO) begin
                if_empty_n <= 1'b0;
            end
        end
    end

    linear_layer_start_fifo_srl #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_srl (
        .clk  (ap_clk),
        .we   (push),
        .addr (ptr[ADDR_WIDTH-1:0]),
        .din  (if_din),
        .dout (if_dout)
    );

endmodule

// File: tb/tb_linear_layer_start_fifo_ctrl.sv
// Bench for linear_layer_start_fifo_ctrl with an 8-bit, two-entry FIFO.
// A queue-based FIFO model supplies expected flags, count and head data.
module tb_linear_layer_start_fifo_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 1;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          write_ce = 1'b0;
    logic          write = 1'b0;
    logic [DW-1:0] din = '0;
    logic          full_n;
    logic          read_ce = 1'b0;
    logic          read = 1'b0;
    logic [DW-1:0] dout;
    logic          empty_n;
    logic [AW:0]   count;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] model_q [$];

    linear_layer_start_fifo_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH)
    ) dut (
        .ap_clk      (clk),
        .ap_rst_n    (rst_n),
        .if_write_ce (write_ce),
        .if_write    (write),
        .if_din      (din),
        .if_full_n   (full_n),
        .if_read_ce  (read_ce),
        .if_read     (read),
        .if_dout     (dout),
        .if_empty_n  (empty_n),
        .if_count    (count)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Drive one cycle of requests, let the edge pass, update the model and return 1ns after the edge.
    task automatic do_cycle(input logic w, input logic wce, input logic [DW-1:0] d,
                            input logic r, input logic rce);
        bit do_push;
        bit do_pop;
        write    = w;
        write_ce = wce;
        din      = d;
        read     = r;
        read_ce  = rce;
        do_push  = w && wce && (model_q.size() < DEPTH);
        do_pop   = r && rce && (model_q.size() > 0);
        @(posedge clk);
        #1;
        if (do_pop)  void'(model_q.pop_front());
        if (do_push) model_q.push_back(d);
        write    = 1'b0;
        write_ce = 1'b0;
        read     = 1'b0;
        read_ce  = 1'b0;
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        #1;
        checks++; if (empty_n !== 1'b0) begin failures++; $display("[TB] FAIL reset_empty_n actual=%0b expected=0", empty_n); end
        checks++; if (full_n !== 1'b1) begin failures++; $display("[TB] FAIL reset_full_n actual=%0b expected=1", full_n); end
        checks++; if (count !== 2'd0) begin failures++; $display("[TB] FAIL reset_count actual=%0d expected=0", count); end
        @(posedge clk);
        #2 rst_n = 1'b1;
        model_q.delete();
        for (int i = 0; i < 5; i++) begin
            do_cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
            checks++;
            if (empty_n !== 1'b0 || full_n !== 1'b1 || count !== 2'd0) begin
                failures++;
                $display("[TB] FAIL idle_after_reset cycle=%0d actual empty_n=%0b full_n=%0b count=%0d expected 0/1/0",
                         i, empty_n, full_n, count);
            end
        end
    endtask

    task automatic test_fill();
        do_cycle(1'b1, 1'b1, 8'hA1, 1'b0, 1'b0);
        checks++; if (empty_n !== 1'b1) begin failures++; $display("[TB] FAIL fill1_empty_n actual=%0b expected=1", empty_n); end
        checks++; if (dout !== 8'hA1) begin failures++; $display("[TB] FAIL fill1_dout actual=%02h expected=a1", dout); end
        checks++; if (count !== 2'd1 || full_n !== 1'b1) begin failures++; $display("[TB] FAIL fill1_count_full actual count=%0d full_n=%0b expected 1/1", count, full_n); end
        do_cycle(1'b1, 1'b1, 8'hB2, 1'b0, 1'b0);
        checks++; if (full_n !== 1'b0) begin failures++; $display("[TB] FAIL fill2_full_n actual=%0b expected=0", full_n); end
        checks++; if (count !== 2'd2) begin failures++; $display("[TB] FAIL fill2_count actual=%0d expected=2", count); end
        checks++; if (dout !== 8'hA1) begin failures++; $display("[TB] FAIL fill2_dout actual=%02h expected=a1", dout); end
        do_cycle(1'b1, 1'b1, 8'hC3, 1'b0, 1'b0);
        checks++; if (count !== 2'd2 || full_n !== 1'b0) begin failures++; $display("[TB] FAIL fill3_dropped actual count=%0d full_n=%0b expected 2/0", count, full_n); end
        checks++; if (dout !== 8'hA1) begin failures++; $display("[TB] FAIL fill3_dout actual=%02h expected=a1", dout); end
    endtask

    task automatic test_drain();
        checks++; if (dout !== 8'hA1) begin failures++; $display("[TB] FAIL drain_head0 actual=%02h expected=a1", dout); end
        do_cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        checks++; if (dout !== 8'hB2) begin failures++; $display("[TB] FAIL drain_head1 actual=%02h expected=b2", dout); end
        checks++; if (full_n !== 1'b1 || empty_n !== 1'b1 || count !== 2'd1) begin failures++; $display("[TB] FAIL drain1_flags actual full_n=%0b empty_n=%0b count=%0d expected 1/1/1", full_n, empty_n, count); end
        do_cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        checks++; if (empty_n !== 1'b0 || count !== 2'd0) begin failures++; $display("[TB] FAIL drain2_empty actual empty_n=%0b count=%0d expected 0/0", empty_n, count); end
        do_cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        checks++; if (empty_n !== 1'b0 || full_n !== 1'b1 || count !== 2'd0) begin failures++; $display("[TB] FAIL drain3_ignored actual empty_n=%0b full_n=%0b count=%0d expected 0/1/0", empty_n, full_n, count); end
    endtask

    task automatic test_streaming();
        do_cycle(1'b1, 1'b1, 8'h10, 1'b0, 1'b0);
        for (int v = 8'h11; v <= 8'h1F; v++) begin
            checks++;
            if (dout !== 8'(v - 1)) begin failures++; $display("[TB] FAIL stream_head actual=%02h expected=%02h", dout, 8'(v - 1)); end
            do_cycle(1'b1, 1'b1, 8'(v), 1'b1, 1'b1);
            checks++;
            if (count !== 2'd1 || full_n !== 1'b1 || empty_n !== 1'b1) begin
                failures++;
                $display("[TB] FAIL stream_flags actual count=%0d full_n=%0b empty_n=%0b expected 1/1/1", count, full_n, empty_n);
            end
        end
        checks++; if (dout !== 8'h1F) begin failures++; $display("[TB] FAIL stream_last actual=%02h expected=1f", dout); end
        do_cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        checks++; if (empty_n !== 1'b0 || count !== 2'd0) begin failures++; $display("[TB] FAIL stream_end actual empty_n=%0b count=%0d expected 0/0", empty_n, count); end
    endtask

    task automatic test_clock_enables();
        do_cycle(1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            do_cycle(1'b1, 1'b0, 8'h88, 1'b1, 1'b0);
            checks++;
            if (count !== 2'd1 || dout !== 8'h77 || empty_n !== 1'b1 || full_n !== 1'b1) begin
                failures++;
                $display("[TB] FAIL ce_hold cycle=%0d actual count=%0d dout=%02h empty_n=%0b full_n=%0b expected 1/77/1/1",
                         i, count, dout, empty_n, full_n);
            end
        end
        do_cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    endtask

    task automatic test_async_reset();
        do_cycle(1'b1, 1'b1, 8'h21, 1'b0, 1'b0);
        do_cycle(1'b1, 1'b1, 8'h22, 1'b0, 1'b0);
        checks++; if (full_n !== 1'b0 || count !== 2'd2) begin failures++; $display("[TB] FAIL async_prefill actual full_n=%0b count=%0d expected 0/2", full_n, count); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (empty_n !== 1'b0 || full_n !== 1'b1 || count !== 2'd0) begin
            failures++;
            $display("[TB] FAIL async_reset_now actual empty_n=%0b full_n=%0b count=%0d expected 0/1/0", empty_n, full_n, count);
        end
        model_q.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
        do_cycle(1'b1, 1'b1, 8'h5A, 1'b0, 1'b0);
        checks++; if (dout !== 8'h5A || empty_n !== 1'b1 || count !== 2'd1) begin failures++; $display("[TB] FAIL async_after actual dout=%02h empty_n=%0b count=%0d expected 5a/1/1", dout, empty_n, count); end
        do_cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    endtask

    task automatic test_random();
        logic [DW-1:0] exp_count;
        for (int i = 0; i < 300; i++) begin
            do_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 8'($urandom),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
            exp_count = 8'(model_q.size());
            checks++;
            if ({6'd0, count} !== exp_count || empty_n !== (model_q.size() > 0) ||
                full_n !== (model_q.size() < DEPTH)) begin
                failures++;
                $display("[TB] FAIL random_state cycle=%0d actual count=%0d empty_n=%0b full_n=%0b expected count=%0d",
                         i, count, empty_n, full_n, exp_count);
            end
            if (model_q.size() > 0) begin
                checks++;
                if (dout !== model_q[0]) begin
                    failures++;
                    $display("[TB] FAIL random_dout cycle=%0d actual=%02h expected=%02h", i, dout, model_q[0]);
                end
            end
        end
    endtask

    // Run the scenarios in order, then report.
    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_streaming();
        test_clock_enables();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
